// File: rtl/bus_halt_sequencer_if.sv
// bus_halt_sequencer_if
//   Groups the bus-cycle and DMA handshake signals of the halt sequencer.
//   master : the side that produces bus-cycle strobes and DMA requests
//            (CPU bus timing plus the video/DMA fetch engine).
//   slave  : the bus_halt_sequencer itself.
//
//   cycle_en  strobe, end of each CPU bus cycle
//   r_w_cpu   CPU R/W of the current bus cycle (1 = read)
//   dma_req   level DMA burst request
//   dma_len   burst length in bus cycles
//   dma_ack   one-clock pulse, request accepted and length latched
//   dma_cycle high for each bus cycle owned by DMA
//   dma_done  one-clock pulse when the DMA state is left
//   aec       1 = CPU drives address/R/W, 0 = adapter tristates them
//   _rdy      active-low ready to the CPU
interface bus_halt_sequencer_if #(
  parameter int LEN_W = 6
);
  logic             cycle_en;
  logic             r_w_cpu;
  logic             dma_req;
  logic [LEN_W-1:0] dma_len;
  logic             dma_ack;
  logic             dma_cycle;
  logic             dma_done;
  logic             aec;
  logic             _rdy;

  modport master (
    output cycle_en, r_w_cpu, dma_req, dma_len,
    input  dma_ack, dma_cycle, dma_done, aec, _rdy
  );

  modport slave (
    input  cycle_en, r_w_cpu, dma_req, dma_len,
    output dma_ack, dma_cycle, dma_done, aec, _rdy
  );
endinterface

// File: rtl/bus_halt_sequencer.sv
// bus_halt_sequencer
//   Generates aec and active-low _rdy for the 6502->7501 bus adapter so a
//   video/DMA fetch engine can own the bus for an N-cycle burst. _rdy drops
//   HALT_LEAD bus cycles before aec falls, because the CPU ignores RDY on
//   write cycles and may still need up to HALT_LEAD writes before it stalls.
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-high reset
//   bus        bus_halt_sequencer_if.slave (strobe, R/W, DMA handshake, aec, _rdy)
//   state_dbg  current FSM state (0 IDLE, 1 HALT, 2 DMA, 3 RELEASE)
//
// Handshake: dma_req is a level request. It is only looked at in IDLE on a
//   cycle_en clock; if dma_len is non-zero the request is accepted on that
//   strobe, dma_len is latched and dma_ack pulses for exactly one clock.
//   dma_req/dma_len are ignored in every other state, and a request still
//   held when IDLE is re-entered starts a fresh burst.
//
// Optional build macro: EARLY_GRAB_EN
//   When defined, a read strobe (r_w_cpu=1) during HALT proves the CPU has
//   stalled and the bus is taken at once; the lead counter still bounds the
//   wait. When undefined the wait is always HALT_LEAD strobes.
module bus_halt_sequencer #(
  parameter int HALT_LEAD = 3,
  parameter int LEN_W     = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_halt_sequencer_if.slave   bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HALT    = 2'd1,
    ST_DMA     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [2:0]       LEAD_INIT = 3'(HALT_LEAD);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       lead_q, lead_d;
  logic [LEN_W-1:0] burst_q, burst_d;
  logic             aec_q, aec_d;
  logic             rdy_n_q, rdy_n_d;
  logic             dma_cycle_q, dma_cycle_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             early_grab;

`ifdef EARLY_GRAB_EN
  assign early_grab = bus.r_w_cpu;
`else
  logic unused_r_w_cpu;
  assign early_grab     = 1'b0;
  assign unused_r_w_cpu = bus.r_w_cpu;
`endif

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    burst_d = burst_q;
    ack_d   = 1'b0;   // pulses last one clock regardless of cycle_en
    done_d  = 1'b0;

    if (bus.cycle_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.dma_req && (bus.dma_len != '0)) begin
            // The burst counter holds the latched length through HALT.
            burst_d = bus.dma_len;
            lead_d  = LEAD_INIT;
            ack_d   = 1'b1;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          lead_d = lead_q - 3'd1;
          if ((lead_q <= 3'd1) || early_grab) begin
            lead_d  = 3'd0;
            state_d = ST_DMA;
          end
        end
        ST_DMA: begin
          burst_d = burst_q - LEN_ONE;
          if (burst_q <= LEN_ONE) begin
            burst_d = '0;
            done_d  = 1'b1;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are registered with it;
    // aec=0 only in DMA, and _rdy=1 only in IDLE, so aec=0 always has _rdy=0.
    aec_d       = (state_d != ST_DMA);
    rdy_n_d     = (state_d == ST_IDLE);
    dma_cycle_d = (state_d == ST_DMA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lead_q      <= 3'd0;
      burst_q     <= '0;
      aec_q       <= 1'b1;
      rdy_n_q     <= 1'b1;
      dma_cycle_q <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lead_q      <= lead_d;
      burst_q     <= burst_d;
      aec_q       <= aec_d;
      rdy_n_q     <= rdy_n_d;
      dma_cycle_q <= dma_cycle_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
    end
  end

  assign bus.aec       = aec_q;
  assign bus._rdy      = rdy_n_q;
  assign bus.dma_cycle = dma_cycle_q;
  assign bus.dma_ack   = ack_q;
  assign bus.dma_done  = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bus_halt_sequencer.sv
module tb_bus_halt_sequencer;

  // Output vector encoding: {dma_ack, _rdy, aec, dma_cycle, dma_done}
  localparam logic [4:0] O_IDLE = 5'b01100;
  localparam logic [4:0] O_ACK  = 5'b10100;
  localparam logic [4:0] O_HALT = 5'b00100;
  localparam logic [4:0] O_DMA  = 5'b00010;
  localparam logic [4:0] O_DONE = 5'b00101;
  localparam logic [4:0] O_REL  = 5'b00100;
  localparam logic [4:0] PULSE_MASK = 5'b01110;

  typedef struct {
    logic       ce;
    logic       rw;
    logic       req;
    logic [5:0] len;
    logic [4:0] exp;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;
  logic [4:0] obs;
  logic [4:0] exp_q[$];
  vec_t       vecs[$];
  logic [4:0] g_exp [7];
  int         n_vec;
  int         n_err;
  int         aec_low;

  bus_halt_sequencer_if #(.LEN_W(6)) bus ();

  bus_halt_sequencer #(.HALT_LEAD(3), .LEN_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  assign obs = {bus.dma_ack, bus._rdy, bus.aec, bus.dma_cycle, bus.dma_done};

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic step(input logic ce, input logic rw, input logic req,
                      input logic [5:0] len);
    bus.cycle_en = ce;
    bus.r_w_cpu  = rw;
    bus.dma_req  = req;
    bus.dma_len  = len;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic ce, input logic rw, input logic req,
                     input logic [5:0] len, input logic [4:0] exp);
    vec_t v;
    v.ce = ce; v.rw = rw; v.req = req; v.len = len; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // aec=0 must always come with _rdy=0.
  always @(negedge clock) begin
    n_vec++;
    if (!bus.aec && bus._rdy) begin
      n_err++;
      $display("FAIL invariant: aec=%b _rdy=%b (t=%0t)", bus.aec, bus._rdy, $time);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    bus.cycle_en = 1'b0;
    bus.r_w_cpu  = 1'b0;
    bus.dma_req  = 1'b0;
    bus.dma_len  = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check("reset_state", 32'(obs), 32'(O_IDLE));
    check("reset_state_dbg", 32'(state_dbg), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic burst, len=5, with held (cycle_en=0) clocks in HALT and DMA.
    add(1, 0, 1, 5, O_ACK);
    add(0, 0, 0, 5, O_HALT);
    add(1, 0, 0, 0, O_HALT);
    add(1, 0, 0, 0, O_HALT);
    add(1, 0, 0, 0, O_DMA);
    add(0, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DONE);
    add(0, 0, 0, 0, O_REL);
    add(1, 0, 0, 0, O_IDLE);
    // Zero-length request is ignored.
    add(1, 0, 1, 0, O_IDLE);
    add(1, 0, 1, 0, O_IDLE);
    add(1, 0, 1, 0, O_IDLE);
    add(0, 0, 1, 0, O_IDLE);
    // Request held across a len=2 burst; length changed to 3 mid-burst.
    add(1, 0, 1, 2, O_ACK);
    add(1, 0, 1, 3, O_HALT);
    add(1, 0, 1, 3, O_HALT);
    add(1, 0, 1, 3, O_DMA);
    add(1, 0, 1, 3, O_DMA);
    add(1, 0, 1, 3, O_DONE);
    add(1, 0, 1, 3, O_IDLE);
    add(1, 0, 1, 3, O_ACK);
    add(1, 0, 0, 0, O_HALT);
    add(1, 0, 0, 0, O_HALT);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DMA);
    add(1, 0, 0, 0, O_DONE);
    add(1, 0, 0, 0, O_IDLE);
    // Read strobe on the second HALT strobe.
    add(1, 0, 1, 2, O_ACK);
    add(1, 0, 0, 0, O_HALT);
`ifdef EARLY_GRAB_EN
    add(1, 1, 0, 0, O_DMA);
    add(1, 1, 0, 0, O_DMA);
    add(1, 1, 0, 0, O_DONE);
    add(1, 1, 0, 0, O_IDLE);
`else
    add(1, 1, 0, 0, O_HALT);
    add(1, 1, 0, 0, O_DMA);
    add(1, 1, 0, 0, O_DMA);
    add(1, 1, 0, 0, O_DONE);
    add(1, 1, 0, 0, O_IDLE);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      step(vecs[i].ce, vecs[i].rw, vecs[i].req, vecs[i].len);
      check($sformatf("vec%0d", i), 32'(obs), 32'(exp_q.pop_front()));
    end

    // Gapped strobes: one cycle_en every 4 clocks, len=2.
    g_exp[0] = O_ACK;  g_exp[1] = O_HALT; g_exp[2] = O_HALT; g_exp[3] = O_DMA;
    g_exp[4] = O_DMA;  g_exp[5] = O_DONE; g_exp[6] = O_IDLE;
    aec_low = 0;
    for (int s = 0; s < 7; s++) begin
      step(1'b1, 1'b0, (s == 0), (s == 0) ? 6'd2 : 6'd0);
      check($sformatf("gap_strobe%0d", s), 32'(obs), 32'(g_exp[s]));
      if (!bus.aec) aec_low++;
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'b0, 6'd0);
        check($sformatf("gap_hold%0d_%0d", s, g), 32'(obs),
              32'(g_exp[s] & PULSE_MASK));
        if (!bus.aec) aec_low++;
      end
    end
    check("gap_aec_low_clocks", 32'(aec_low), 32'd8);

    // Asynchronous reset in the middle of a burst.
    step(1, 0, 1, 4);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("pre_reset_dma", 32'(obs), 32'(O_DMA));
    #3 reset = 1'b1;
    #1 check("async_reset", 32'(obs), 32'(O_IDLE));
    check("async_reset_state", 32'(state_dbg), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check($sformatf("post_reset%0d", i), 32'(obs), 32'(O_IDLE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_halt_sequencer.md
Name: bus_halt_sequencer

Overview:
- Generates `aec` and active-low `_rdy` for the 6502→7501 bus adapter, which sits directly downstream of this block.
- Lets a video/DMA fetch engine take the bus for an N-cycle burst.
- The CPU ignores RDY on write cycles, so `_rdy` drops `HALT_LEAD` bus cycles before `aec` falls. This lets the CPU finish up to `HALT_LEAD` consecutive writes before it stops on a read.

Parameters:
- HALT_LEAD, 3, bus cycles `_rdy` is low before `aec` is released (range 1..7)
- LEN_W, 6, width of burst-length request

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cycle_en  in  1  one-clock strobe marking the end of each CPU bus cycle; all state advances only on clocks where cycle_en=1
- r_w_cpu  in  1  CPU R/W for the current bus cycle (1=read), sampled with cycle_en
- dma_req  in  1  level request for a DMA burst
- dma_len  in  LEN_W  burst length in bus cycles, sampled when the request is accepted
- dma_ack  out  1  one-clock pulse: request accepted and length latched
- dma_cycle  out  1  high for each bus cycle owned by DMA (aec=0)
- dma_done  out  1  one-clock pulse on the clock that leaves the DMA state
- aec  out  1  1=CPU drives address/R/W, 0=adapter tristates them
- _rdy  out  1  active-low ready to CPU (feeds the adapter's `_rdy_7501`)

Behaviour:
- Registered outputs; all transitions on the rising clock edge qualified by cycle_en, unless stated otherwise.
- Reset (async):
  - state=IDLE, aec=1, _rdy=1, dma_cycle=0, dma_ack=0, dma_done=0
  - lead and burst counters=0
  - takes effect immediately, including mid-burst.
- Reset release: first cycle_en evaluates IDLE.
- IDLE (aec=1, _rdy=1):
  - On cycle_en with dma_req=1 and dma_len≠0: latch len, load lead counter=HALT_LEAD, pulse dma_ack, go to HALT.
  - dma_req with dma_len=0: ignored, no ack, stay IDLE.
- HALT (aec=1, _rdy=0):
  - Each cycle_en decrements the lead counter.
  - When the counter reaches 0, go to DMA with burst counter=len.
  - r_w_cpu is ignored here unless the optional feature is enabled.
- DMA (aec=0, _rdy=0, dma_cycle=1):
  - Each cycle_en decrements the burst counter.
  - On the cycle_en where the counter goes 1→0: pulse dma_done, go to RELEASE.
  - Burst occupies exactly len bus cycles.
- RELEASE (aec=1, _rdy=0):
  - One bus cycle of turnaround so the CPU re-drives the address before resuming.
  - Next cycle_en: go to IDLE (_rdy=1).
- Latency:
  - dma_req accepted at cycle_en k.
  - aec=0 from cycle k+HALT_LEAD+1 through k+HALT_LEAD+len.
  - _rdy=1 again at cycle k+HALT_LEAD+len+2.
- dma_req or dma_len changes during HALT/DMA/RELEASE: ignored. A request still held in IDLE starts a new burst; there is no back-to-back merge.
- cycle_en=0: all state and outputs hold.
- Pulses (dma_ack, dma_done): exactly one clock wide, asserted on the clock following the cycle_en edge that caused them.
- Invariant: aec=0 implies _rdy=0. This must never be violated, including on reset assertion.

Optional Feature:
- Macro: EARLY_GRAB_EN
- Defined:
  - In HALT, a cycle_en with r_w_cpu=1 proves the CPU has stalled on a read.
  - The block transitions to DMA on that cycle_en regardless of the remaining lead count.
  - The lead counter still bounds the wait at HALT_LEAD.
- Undefined:
  - Fixed HALT_LEAD wait; r_w_cpu is unused.

Test Plan:
1. Reset: assert reset mid-DMA (aec=0) → aec=1, _rdy=1, dma_cycle=0 within the same clock, asynchronously; after release with dma_req=0, the outputs stay idle.
2. Basic burst, HALT_LEAD=3, dma_len=5, request at cycle_en k:
   - dma_ack at k
   - _rdy=0 from k+1
   - aec=0 exactly for cycles k+4..k+8
   - dma_done at k+8
   - _rdy=1 at k+10
3. dma_len=0 with dma_req=1 → no dma_ack, aec and _rdy stay 1 indefinitely.
4. dma_req held high across the burst → second dma_ack only on the first cycle_en after RELEASE returns to IDLE; the length change made mid-burst is latched only then.
5. cycle_en gapped (1 strobe every 4 clocks) during a len=2 burst → counts advance only on strobes; aec=0 spans exactly 2 strobes.
6. EARLY_GRAB_EN defined, r_w_cpu = 0,1 on the first two HALT strobes → aec=0 from the cycle after the second strobe; without the macro, the wait is still the full 3 strobes.
